// File: rtl/extio8x4_init_ctrl.sv
// Initiator sequencer for the extio link: sends each stream byte as two nibbles
// (low first) over a 4-phase req/ack handshake, with a sticky wait-timeout flag.
module extio8x4_init_ctrl #(
    parameter int TMO_W = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       testmode,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [3:0] io_data,
    output logic       io_req,
    input  logic       io_ack,
    output logic       tmo_err,
    input  logic       tmo_clr,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, LO_SET, LO_REQ, LO_REL, HI_SET, HI_REQ, HI_REL
    } state_t;

    localparam logic [TMO_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [3:0]       hi_q, hi_d;
    logic [3:0]       data_q, data_d;
    logic             req_q, req_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             sync1_q, sync2_q;
    logic             ack_s;
    logic             new_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= io_ack;
            sync2_q <= sync1_q;
        end
    end

    assign ack_s = testmode ? io_ack : sync2_q;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (s_tvalid) begin
                    hi_d    = s_tdata[7:4];
                    data_d  = s_tdata[3:0];
                    state_d = LO_SET;
                end
            end
            // SET states refuse to raise req while a stale ack is still high
            LO_SET: if (!ack_s) state_d = LO_REQ;
            LO_REQ: if (ack_s)  state_d = LO_REL;
            LO_REL: begin
                if (!ack_s) begin
                    data_d  = hi_q;
                    state_d = HI_SET;
                end
            end
            HI_SET: if (!ack_s) state_d = HI_REQ;
            HI_REQ: if (ack_s)  state_d = HI_REL;
            HI_REL: if (!ack_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_d = (state_d == LO_REQ) || (state_d == HI_REQ);

        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q != IDLE) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end

        // A fresh saturation beats a clear; a clear while already saturated
        // holds for one cycle before the level re-asserts the flag.
        new_sat = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
        err_d   = err_q;
        if (new_sat) begin
            err_d = 1'b1;
        end else if (tmo_clr) begin
            err_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= 4'h0;
            data_q  <= 4'h0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign s_tready = (state_q == IDLE) && !reset;
    assign busy     = (state_q != IDLE);
    assign io_data  = data_q;
    assign io_req   = req_q;
    assign tmo_err  = err_q;

endmodule

// File: tb/tb_extio8x4_init_ctrl.sv
// Directed bench for extio8x4_init_ctrl with a switchable responder model
// (req loopback, forced ack level, or randomly delayed follower).
module tb_extio8x4_init_ctrl;

    logic       clk = 1'b0;
    logic       reset, testmode, s_tvalid, tmo_clr;
    logic [7:0] s_tdata;
    logic       s_tready, io_req, io_ack, tmo_err, busy;
    logic [3:0] io_data;

    int   total = 0;
    int   bad   = 0;
    int   ack_mode;
    logic ack_force;
    logic resp_ack = 1'b0;
    int   dly = 3;

    logic [15:0] req_t, rdy_t, bsy_t;
    logic [3:0]  dat_t [16];
    logic [3:0]  rise_d [2];
    int          nrise;
    logic [3:0]  nq [$];
    logic [3:0]  exp_nib [6];
    int          nacc, gap, first;
    logic        prev, acc_now;
    bit          done;

    extio8x4_init_ctrl #(.TMO_W(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .testmode (testmode),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .io_data  (io_data),
        .io_req   (io_req),
        .io_ack   (io_ack),
        .tmo_err  (tmo_err),
        .tmo_clr  (tmo_clr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign io_ack = (ack_mode == 0) ? io_req : (ack_mode == 1) ? ack_force : resp_ack;

    always @(posedge clk) begin
        if (resp_ack != io_req) begin
            if (dly <= 0) begin
                resp_ack <= io_req;
                dly      <= $urandom_range(0, 4);
            end else begin
                dly <= dly - 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic trace_byte(input logic [7:0] b);
        @(posedge clk); #1;
        s_tdata  = b;
        s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        req_t = '0;
        rdy_t = '0;
        bsy_t = '0;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            req_t[i] = io_req;
            rdy_t[i] = s_tready;
            bsy_t[i] = busy;
            dat_t[i] = io_data;
        end
    endtask

    task automatic run_to_idle(input int budget, input string tag);
        logic p;
        p     = io_req;
        nrise = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (io_req && !p) begin
                if (nrise < 2) rise_d[nrise] = io_data;
                nrise++;
            end
            p = io_req;
            if (!busy) break;
        end
        check_val({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        testmode  = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = 8'h00;
        tmo_clr   = 1'b0;
        ack_mode  = 0;
        ack_force = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_rdy",  s_tready, 0);
        check_val("rst_req",  io_req,   0);
        check_val("rst_dat",  io_data,  0);
        check_val("rst_busy", busy,     0);
        check_val("rst_err",  tmo_err,  0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("rdy_after_rst", s_tready, 1);

        // single byte, synchronised ack, zero-delay loopback
        trace_byte(8'hA5);
        check_val("sync_req",  req_t, 16'h0E1C);
        check_val("sync_rdy",  rdy_t, 16'h8000);
        check_val("sync_busy", bsy_t, 16'h7FFE);
        check_val("sync_d1",   dat_t[1],  4'h5);
        check_val("sync_d7",   dat_t[7],  4'h5);
        check_val("sync_d8",   dat_t[8],  4'hA);
        check_val("sync_d14",  dat_t[14], 4'hA);

        // same byte with the synchroniser bypassed
        testmode = 1'b1;
        trace_byte(8'hA5);
        check_val("tm_req",  req_t, 16'h0024);
        check_val("tm_rdy",  rdy_t, 16'hFF80);
        check_val("tm_busy", bsy_t, 16'h007E);
        check_val("tm_d1",   dat_t[1], 4'h5);
        check_val("tm_d3",   dat_t[3], 4'h5);
        check_val("tm_d4",   dat_t[4], 4'hA);
        check_val("tm_d6",   dat_t[6], 4'hA);
        testmode = 1'b0;

        // three back-to-back bytes against a randomly delayed responder
        ack_mode = 2;
        exp_nib  = '{4'h1, 4'h0, 4'h3, 4'h2, 4'h5, 4'h4};
        nacc = 0;
        gap  = 0;
        prev = 1'b0;
        done = 1'b0;
        @(posedge clk); #1;
        s_tdata  = 8'h01;
        s_tvalid = 1'b1;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            if (io_req && !prev) nq.push_back(io_data);
            prev = io_req;
            if (nacc == 3 && !busy) begin
                done = 1'b1;
            end else begin
                if (!busy && nacc > 0) gap++;
                acc_now = s_tready && s_tvalid;
                @(posedge clk); #1;
                if (acc_now) begin
                    nacc++;
                    if (nacc == 1)      s_tdata = 8'h23;
                    else if (nacc == 2) s_tdata = 8'h45;
                    else                s_tvalid = 1'b0;
                end
            end
        end
        check_val("b3_done",  done, 1);
        check_val("b3_count", nq.size(), 6);
        for (int i = 0; i < 6; i++)
            check_val($sformatf("b3_nib%0d", i), (i < nq.size()) ? 32'(nq[i]) : 32'hDEAD, 32'(exp_nib[i]));
        check_val("b3_gap", gap, 2);

        // ack stuck low in LO_REQ: timeout, clear while saturated, then recovery
        ack_mode  = 1;
        ack_force = 1'b0;
        @(posedge clk); #1;
        s_tdata  = 8'h3C;
        s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        first = 0;
        for (int c = 1; c <= 1200; c++) begin
            @(negedge clk);
            if (tmo_err) begin
                first = c;
                break;
            end
        end
        check_val("tmo_cycle", first, 1025);
        check_val("tmo_req",   io_req, 1);
        check_val("tmo_dat",   io_data, 4'hC);
        check_val("tmo_rdy",   s_tready, 0);
        @(posedge clk); #1;
        tmo_clr = 1'b1;
        @(posedge clk); #1;
        tmo_clr = 1'b0;
        @(negedge clk);
        check_val("tmo_clr_sat", tmo_err, 0);
        @(negedge clk);
        check_val("tmo_resat", tmo_err, 1);
        ack_mode = 0;
        run_to_idle(100, "tmo");
        check_val("tmo_hi_nib", rise_d[0], 4'h3);
        check_val("tmo_sticky", tmo_err, 1);
        @(posedge clk); #1;
        tmo_clr = 1'b1;
        @(posedge clk); #1;
        tmo_clr = 1'b0;
        @(negedge clk);
        check_val("tmo_cleared", tmo_err, 0);
        @(negedge clk);
        check_val("tmo_stays0", tmo_err, 0);

        // stale ack held high before the byte arrives
        ack_mode  = 1;
        ack_force = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        s_tdata  = 8'h96;
        s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        repeat (10) @(negedge clk);
        check_val("stale_req",  io_req, 0);
        check_val("stale_busy", busy, 1);
        check_val("stale_dat",  io_data, 4'h6);
        ack_mode = 0;
        run_to_idle(100, "stale");
        check_val("stale_nrise", nrise, 2);
        check_val("stale_lo", rise_d[0], 4'h6);
        check_val("stale_hi", rise_d[1], 4'h9);

        // reset asserted during HI_REQ
        @(posedge clk); #1;
        s_tdata  = 8'h5A;
        s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        repeat (9) @(negedge clk);
        check_val("mid_req_pre", io_req, 1);
        check_val("mid_dat_pre", io_data, 4'h5);
        #1;
        reset = 1'b1;
        #1;
        check_val("mid_req_async", io_req, 0);
        check_val("mid_busy_async", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rdy",  s_tready, 1);
        check_val("post_busy", busy, 0);
        check_val("post_err",  tmo_err, 0);
        check_val("post_dat",  io_data, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
